// File: rtl/pakin_if.sv
`default_nettype none
// ============================================================================
// Module   : pakin_pkt_if / pakin_msg_if
// Brief    : 4-phase packet channel and 4-phase message channel for pakin.
// Revision : 1.0
// ============================================================================

interface pakin_pkt_if #(
    parameter int PSZ = 4
);
    logic [PSZ-1:0] pakio;
    logic           req;
    logic           ack;

    modport master (output pakio, output req, input  ack);
    modport slave  (input  pakio, input  req, output ack);
endinterface

interface pakin_msg_if #(
    parameter int ASZ = 6,
    parameter int DSZ = 4,
    parameter int RSZ = 2
);
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] data;
    logic [RSZ-1:0] red;
    logic           req;
    logic           ack;

    modport master (output addr, output data, output red, output req, input  ack);
    modport slave  (input  addr, input  data, input  red, input  req, output ack);
endinterface

`default_nettype wire

// File: rtl/pakin.sv
`default_nettype none
// ============================================================================
// Module   : pakin
// Brief    : Reassembles PSZ-bit packets into {addr,data,red} messages, queues
//            them in a FIFO; PAKIN_RED_CHK_EN enables the redundancy check.
// Revision : 1.0
// ============================================================================

module pakin #(
    parameter int PSZ    = 4,
    parameter int ASZ    = 6,
    parameter int DSZ    = 4,
    parameter int RSZ    = 2,
    parameter int FSZ    = 3,
    parameter int FDEPTH = 4
) (
    input  wire          i_clk,
    input  wire          reset,
    output logic         ready,
    pakin_pkt_if.slave   rcv0,
    pakin_msg_if.master  snd0,
    output logic         err
);

    localparam int MSZ   = ASZ + DSZ + RSZ;
    localparam int FW    = FSZ * PSZ;
    localparam int PKW   = (FSZ > 1) ? $clog2(FSZ) : 1;
    localparam int SLOTS = (FSZ > 1) ? FSZ - 1 : 1;
    localparam int AW    = $clog2(FDEPTH);
    localparam int CW    = AW + 1;
    localparam logic [PKW-1:0] PK_LAST = PKW'(FSZ - 1);

    logic                       ready_q, ready_d;
    logic                       ack_q, ack_d;
    logic [PKW-1:0]             pk_q, pk_d;
    logic [SLOTS-1:0][PSZ-1:0]  slot_q, slot_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       req_q, req_d;
    logic [MSZ-1:0]             out_q, out_d;
    logic                       err_q, err_d;
    logic [MSZ-1:0]             mem_q [FDEPTH];

    logic           full, empty, is_last, accept, red_ok, push, load, pop;
    logic [FW-1:0]  asm_full;
    logic [MSZ-1:0] asm_msg;

`ifdef PAKIN_RED_CHK_EN
    localparam int NSL = (ASZ + DSZ + RSZ - 1) / RSZ;
    logic [NSL*RSZ-1:0] ad_ext;
    logic [RSZ-1:0]     exp_red;
`endif

    always_comb begin
        full    = (cnt_q == CW'(FDEPTH));
        empty   = (cnt_q == '0);
        is_last = (pk_q == PK_LAST);
        accept  = ready_q && rcv0.req && !ack_q && (!is_last || !full);

        // Packet 0 is the MSB end; the live packet completes the LSB end.
        asm_full = '0;
        for (int k = 0; k < FSZ - 1; k++) begin
            asm_full[FW-1-k*PSZ -: PSZ] = slot_q[k];
        end
        asm_full[PSZ-1:0] = rcv0.pakio;
        asm_msg = asm_full[FW-1 -: MSZ];

`ifdef PAKIN_RED_CHK_EN
        ad_ext  = (NSL*RSZ)'(asm_msg[MSZ-1:RSZ]);
        exp_red = '0;
        for (int i = 0; i < NSL; i++) begin
            exp_red = exp_red ^ ad_ext[i*RSZ +: RSZ];
        end
        red_ok = (exp_red == asm_msg[RSZ-1:0]);
        err_d  = accept && is_last && !red_ok;
`else
        red_ok = 1'b1;
        err_d  = 1'b0;
`endif

        push = accept && is_last && red_ok;
        load = ready_q && !req_q && !snd0.ack && !empty;
        pop  = ready_q && req_q && snd0.ack;

        ready_d = 1'b1;

        ack_d = ack_q;
        if (accept) begin
            ack_d = 1'b1;
        end else if (ready_q && ack_q && !rcv0.req) begin
            ack_d = 1'b0;
        end

        pk_d = pk_q;
        if (accept) begin
            pk_d = is_last ? '0 : pk_q + PKW'(1);
        end

        slot_d = slot_q;
        for (int k = 0; k < FSZ - 1; k++) begin
            if (accept && (pk_q == PKW'(k))) begin
                slot_d[k] = rcv0.pakio;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end

        req_d = req_q;
        out_d = out_q;
        if (load) begin
            req_d = 1'b1;
            out_d = mem_q[rd_ptr_q];
        end else if (pop) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            ready_q  <= 1'b0;
            ack_q    <= 1'b0;
            pk_q     <= '0;
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            pk_q     <= pk_d;
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: the count alone defines which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= asm_msg;
        end
    end

    assign ready     = ready_q;
    assign err       = err_q;
    assign rcv0.ack  = ack_q;
    assign snd0.req  = req_q;
    assign snd0.addr = out_q[MSZ-1 -: ASZ];
    assign snd0.data = out_q[RSZ+DSZ-1 -: DSZ];
    assign snd0.red  = out_q[RSZ-1:0];

endmodule

`default_nettype wire

// File: tb/tb_pakin.sv
`default_nettype none
// ============================================================================
// Module   : tb_pakin
// Brief    : Directed and randomised-delay checks of pakin.
// Revision : 1.0
// ============================================================================

module tb_pakin;

`ifdef PAKIN_RED_CHK_EN
    localparam int EXP_ERRS = 1;
`else
    localparam int EXP_ERRS = 0;
`endif
    localparam int BOUND = 200;

    logic i_clk = 1'b0;
    logic reset = 1'b0;
    logic ready, err;

    always #5 i_clk = ~i_clk;

    pakin_pkt_if #(.PSZ(4)) rcv0 ();
    pakin_msg_if #(.ASZ(6), .DSZ(4), .RSZ(2)) snd0 ();

    pakin #(
        .PSZ(4), .ASZ(6), .DSZ(4), .RSZ(2), .FSZ(3), .FDEPTH(4)
    ) dut (
        .i_clk (i_clk),
        .reset (reset),
        .ready (ready),
        .rcv0  (rcv0),
        .snd0  (snd0),
        .err   (err)
    );

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    logic [11:0] msgs [5];
    logic [11:0] got, exp_m, snd_m;
    logic [11:0] exp_q [$];

    always @(negedge i_clk) if (err === 1'b1) err_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Message whose red field is the XOR of the 2-bit slices of {addr,data}
    function automatic logic [11:0] mk(input logic [9:0] ad);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < 10; i++) r[i % 2] = r[i % 2] ^ ad[i];
        return {ad, r};
    endfunction

    task automatic send_pkt(input logic [3:0] p);
        int n;
        rcv0.pakio = p;
        rcv0.req   = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (rcv0.ack !== 1'b1 && n < BOUND);
        chk("pkt_ack", rcv0.ack, 1);
        rcv0.req = 1'b0;
        n = 0;
        do begin @(negedge i_clk); n++; end while (rcv0.ack !== 1'b0 && n < BOUND);
        chk("pkt_ack_drop", rcv0.ack, 0);
    endtask

    task automatic send_msg(input logic [11:0] m, input int maxgap);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge i_clk);
            send_pkt(m[11-4*k -: 4]);
        end
    endtask

    task automatic recv_msg(input int dly, output logic [11:0] m);
        int n;
        n = 0;
        while (snd0.req !== 1'b1 && n < BOUND) begin @(negedge i_clk); n++; end
        chk("msg_req", snd0.req, 1);
        m = {snd0.addr, snd0.data, snd0.red};
        repeat (dly) @(negedge i_clk);
        chk("msg_hold", {snd0.addr, snd0.data, snd0.red}, m);
        snd0.ack = 1'b1;
        n = 0;
        do begin @(negedge i_clk); n++; end while (snd0.req !== 1'b0 && n < BOUND);
        chk("msg_req_drop", snd0.req, 0);
        snd0.ack = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        rcv0.pakio = '0;
        rcv0.req   = 1'b0;
        snd0.ack   = 1'b0;
        for (int i = 0; i < 5; i++) msgs[i] = mk(10'(37 * i + 100));

        // Reset held low for 5 cycles
        repeat (5) @(negedge i_clk);
        chk("rst_ready", ready, 0);
        chk("rst_ack", rcv0.ack, 0);
        chk("rst_req", snd0.req, 0);
        chk("rst_err", err, 0);
        chk("rst_msg", {snd0.addr, snd0.data, snd0.red}, 0);
        reset = 1'b1;
        #1 chk("ready_before_edge", ready, 0);
        @(negedge i_clk);
        chk("ready_after_edge", ready, 1);

        // Single message 0xA,0x9,0x6 -> addr 0x2A, data 0x5, red 0x2
        send_pkt(4'hA);
        send_pkt(4'h9);
        rcv0.pakio = 4'h6;
        rcv0.req   = 1'b1;
        @(negedge i_clk);
        chk("last_ack_latency", rcv0.ack, 1);
        chk("req_not_yet", snd0.req, 0);
        @(negedge i_clk);
        chk("req_rise", snd0.req, 1);
        chk("addr", snd0.addr, 32'h2A);
        chk("data", snd0.data, 32'h5);
        chk("red", snd0.red, 32'h2);
        rcv0.req = 1'b0;
        snd0.ack = 1'b1;
        @(negedge i_clk);
        chk("rcv_ack_drop", rcv0.ack, 0);
        chk("snd_req_drop", snd0.req, 0);
        snd0.ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("no_spurious_req", snd0.req, 0);

        // Backpressure: 4 messages fill the FIFO, the 5th last packet waits
        for (int i = 0; i < 4; i++) send_msg(msgs[i], 0);
        send_pkt(msgs[4][11:8]);
        send_pkt(msgs[4][7:4]);
        rcv0.pakio = msgs[4][3:0];
        rcv0.req   = 1'b1;
        repeat (8) @(negedge i_clk);
        chk("full_withhold", rcv0.ack, 0);
        chk("head_req", snd0.req, 1);
        chk("head_msg", {snd0.addr, snd0.data, snd0.red}, msgs[0]);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    recv_msg(1, got);
                    chk("bp_order", got, msgs[i]);
                end
            end
            begin
                int n;
                n = 0;
                while (rcv0.ack !== 1'b1 && n < BOUND) begin @(negedge i_clk); n++; end
                chk("late_ack", rcv0.ack, 1);
                rcv0.req = 1'b0;
                n = 0;
                while (rcv0.ack !== 1'b0 && n < BOUND) begin @(negedge i_clk); n++; end
                chk("late_ack_drop", rcv0.ack, 0);
            end
        join

        // Reset in mid-message discards the partial packets
        send_pkt(4'h3);
        send_pkt(4'hC);
        reset = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_ack", rcv0.ack, 0);
        reset = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_ready_back", ready, 1);
        exp_m = mk(10'h2F1);
        send_msg(exp_m, 0);
        recv_msg(0, got);
        chk("post_rst_msg", got, exp_m);
        repeat (10) @(negedge i_clk);
        chk("post_rst_only_one", snd0.req, 0);

`ifdef PAKIN_RED_CHK_EN
        // Bad redundancy: acked, one err pulse, nothing delivered
        send_pkt(4'hA);
        send_pkt(4'h9);
        rcv0.pakio = 4'h5;
        rcv0.req   = 1'b1;
        @(negedge i_clk);
        chk("bad_red_ack", rcv0.ack, 1);
        chk("bad_red_err", err, 1);
        rcv0.req = 1'b0;
        @(negedge i_clk);
        chk("err_one_cycle", err, 0);
        repeat (5) @(negedge i_clk);
        chk("bad_red_dropped", snd0.req, 0);
        send_msg(12'hA96, 0);
        recv_msg(1, got);
        chk("good_after_bad", got, 32'hA96);
`endif

        // Random handshake delays on both sides
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if (failures > 20) break;
                    snd_m = mk(10'($urandom));
                    exp_q.push_back(snd_m);
                    send_msg(snd_m, 7);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    if (failures > 20) break;
                    recv_msg($urandom_range(0, 7), got);
                    exp_m = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
                    chk("rnd_msg", got, exp_m);
                end
            end
        join
        repeat (10) @(negedge i_clk);
        chk("rnd_no_extra", snd0.req, 0);
        chk("err_count", err_cnt, EXP_ERRS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
